// File: rtl/gate_pkg.sv
// gate_pkg: gate op encodings and the shared bitwise gate evaluation
package gate_pkg;
  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_NAND, OP_NOR, OP_NOTA, OP_BUFA
  } op_t;
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] gate_fn(input op_t op, input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b);
    return op == OP_AND  ? a & b    :
           op == OP_OR   ? a | b    :
           op == OP_XOR  ? a ^ b    :
           op == OP_XNOR ? ~(a ^ b) :
           op == OP_NAND ? ~(a & b) :
           op == OP_NOR  ? ~(a | b) :
           op == OP_NOTA ? ~a       : a;
  endfunction
endpackage

// File: rtl/popcount_n.sv
// popcount_n: combinational count of set bits in a WIDTH-bit vector
module popcount_n #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_v,
  output logic [CW-1:0]    o_cnt
);
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < WIDTH; i++) o_cnt = o_cnt + CW'(i_v[i]);
  end
endmodule

// File: rtl/bitwise_gate_pipe.sv
// bitwise_gate_pipe: two-stage valid/ready pipeline computing a bitwise gate plus operand-equality statistics
module bitwise_gate_pipe
  import gate_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int CNT_W = 16,
  localparam int MW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [MW-1:0]    match_cnt,
  output logic             all_eq,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] eq_count
);
  logic             r_s1_valid, r_s2_valid, r_eq;
  logic [WIDTH-1:0] r_s1_y, r_s1_xn, r_y;
  logic [MW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_eq_count;
  logic [WIDTH-1:0] w_y;
  logic [MW-1:0]    w_cnt;
  logic             w_s2_moves, w_s1_moves, w_accept;
  assign w_y        = WIDTH'(gate_fn(op_t'(op), MAX_W'(a), MAX_W'(b)));
  assign w_s2_moves = r_s2_valid & out_ready;
  assign w_s1_moves = r_s1_valid & (~r_s2_valid | w_s2_moves);
  assign in_ready   = ~rst & (~r_s1_valid | w_s1_moves);
  assign w_accept   = in_valid & in_ready;
  popcount_n #(.WIDTH(WIDTH)) u_pop (.i_v(r_s1_xn), .o_cnt(w_cnt));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_y     <= '0;
      r_s1_xn    <= '0;
      r_s2_valid <= 1'b0;
      r_y        <= '0;
      r_cnt      <= '0;
      r_eq       <= 1'b0;
      r_eq_count <= '0;
    end else begin
      r_s1_valid <= w_accept ? 1'b1 : (w_s1_moves ? 1'b0 : r_s1_valid);
      r_s2_valid <= w_s1_moves ? 1'b1 : (w_s2_moves ? 1'b0 : r_s2_valid);
      if (w_accept) begin
        r_s1_y  <= w_y;
        r_s1_xn <= ~(a ^ b);
      end
      if (w_s1_moves) begin
        r_y   <= r_s1_y;
        r_cnt <= w_cnt;
        r_eq  <= &r_s1_xn;
      end
      r_eq_count <= stat_clr ? '0 :
                    (w_s2_moves && r_eq && r_eq_count != '1) ? r_eq_count + 1'b1 : r_eq_count;
    end
  end
  assign out_valid = r_s2_valid;
  assign y         = r_y;
  assign match_cnt = r_cnt;
  assign all_eq    = r_eq;
  assign eq_count  = r_eq_count;
endmodule

// File: tb/tb_bitwise_gate_pipe.sv
// tb_bitwise_gate_pipe: randomized and directed checks of bitwise_gate_pipe against a queue-based reference model
module tb_bitwise_gate_pipe;
  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, stat_clr = 1'b0;
  logic       in_ready, out_valid, all_eq;
  logic [7:0] a = '0, b = '0, y;
  logic [2:0] op = '0;
  logic [3:0] match_cnt;
  logic [1:0] eq_count;
  int n_chk = 0, n_fail = 0;
  logic [12:0] q[$];
  logic [12:0] exp_r, s_got;
  logic        has_exp;
  int          eqm = 0;
  logic        s_acc, s_dlv, s_rst, s_ov, s_ir, s_or, s_clr;
  logic [7:0]  s_a, s_b;
  logic [2:0]  s_op;

  bitwise_gate_pipe #(.WIDTH(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .match_cnt(match_cnt), .all_eq(all_eq),
    .stat_clr(stat_clr), .eq_count(eq_count));

  always #5 clk = ~clk;

  function automatic logic [12:0] ref_fn(input logic [7:0] ra, input logic [7:0] rb, input logic [2:0] rop);
    logic [7:0] ry;
    case (rop)
      3'd0: ry = ra & rb;
      3'd1: ry = ra | rb;
      3'd2: ry = ra ^ rb;
      3'd3: ry = ~(ra ^ rb);
      3'd4: ry = ~(ra & rb);
      3'd5: ry = ~(ra | rb);
      3'd6: ry = ~ra;
      default: ry = ra;
    endcase
    return {ry, 4'($countones(~(ra ^ rb))), ra == rb};
  endfunction

  // Samples one cycle mid-period, then advances the model across the rising edge.
  task automatic tick();
    @(negedge clk);
    s_rst = rst; s_ov = out_valid; s_ir = in_ready; s_or = out_ready; s_clr = stat_clr;
    s_acc = in_valid && in_ready; s_dlv = out_valid && out_ready;
    s_a = a; s_b = b; s_op = op; s_got = {y, match_cnt, all_eq};
    @(posedge clk); #1;
    has_exp = 1'b0;
    if (s_rst) begin
      q.delete(); eqm = 0;
    end else begin
      if (s_dlv && q.size() > 0) begin exp_r = q.pop_front(); has_exp = 1'b1; end
      if (s_acc) q.push_back(ref_fn(s_a, s_b, s_op));
      if (s_clr) eqm = 0;
      else if (s_dlv && has_exp && exp_r[0] && eqm != 3) eqm++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; stat_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (s_ir !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", s_ir); end
    n_chk++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", s_ov); end
    n_chk++; if (s_got !== 13'd0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", s_got); end
    n_chk++; if (eq_count !== 2'd0) begin n_fail++; $display("FAIL reset_eq_count got=%0d exp=0", eq_count); end
    tick();
    n_chk++; if (s_ir !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", s_ir); end
  endtask

  task automatic test_xnor_equal();
    out_ready = 1'b1; a = 8'hA5; b = 8'hA5; op = 3'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_chk++; if (s_acc !== 1'b1) begin n_fail++; $display("FAIL xnor_accept got=%b exp=1", s_acc); end
    tick();
    n_chk++; if (s_ov !== 1'b0) begin n_fail++; $display("FAIL xnor_early_valid got=%b exp=0", s_ov); end
    tick();
    n_chk++; if (s_ov !== 1'b1 || s_got !== {8'hFF, 4'd8, 1'b1})
      begin n_fail++; $display("FAIL xnor_result got=v%b %h exp=v1 %h", s_ov, s_got, {8'hFF, 4'd8, 1'b1}); end
    n_chk++; if (eq_count !== 2'd1) begin n_fail++; $display("FAIL xnor_eq_count got=%0d exp=1", eq_count); end
  endtask

  task automatic test_all_ops();
    logic [7:0] tbl [8] = '{8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h3F, 8'h03, 8'h0F, 8'hF0};
    int k = 0, gaps = 0;
    out_ready = 1'b1; a = 8'hF0; b = 8'hCC;
    for (int i = 0; i < 14; i++) begin
      in_valid = i < 8; op = 3'(i);
      tick();
      if (i < 8) begin
        n_chk++; if (s_acc !== 1'b1) begin n_fail++; $display("FAIL ops_accept_%0d got=%b exp=1", i, s_acc); end
      end
      if (s_dlv && k < 8) begin
        n_chk++; if (s_got !== {tbl[k], 4'd4, 1'b0})
          begin n_fail++; $display("FAIL ops_result_%0d got=%h exp=%h", k, s_got, {tbl[k], 4'd4, 1'b0}); end
        k++;
      end else if (k > 0 && k < 8) gaps++;
    end
    n_chk++; if (k !== 8 || gaps !== 0) begin n_fail++; $display("FAIL ops_count got=%0d gaps=%0d exp=8 gaps=0", k, gaps); end
  endtask

  task automatic test_back_to_back_stall();
    int acc = 0, dl = 0;
    logic [12:0] held;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      tick();
      acc += int'(s_acc);
      if (i == 2) held = s_got;
      if (i >= 2) begin
        n_chk++; if (s_ir !== 1'b0 || s_ov !== 1'b1) begin n_fail++; $display("FAIL stall_ready_%0d got=ir%b ov%b exp=ir0 ov1", i, s_ir, s_ov); end
      end
      if (i == 3) begin
        n_chk++; if (s_got !== held) begin n_fail++; $display("FAIL stall_hold got=%h exp=%h", s_got, held); end
      end
    end
    n_chk++; if (acc !== 2) begin n_fail++; $display("FAIL stall_accepted got=%0d exp=2", acc); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_dlv) begin
        dl++;
        n_chk++; if (!has_exp || s_got !== exp_r) begin n_fail++; $display("FAIL stall_drain got=%h exp=%h", s_got, exp_r); end
      end
    end
    n_chk++; if (dl !== 2 || q.size() !== 0) begin n_fail++; $display("FAIL stall_drain_count got=%0d exp=2", dl); end
  endtask

  task automatic test_saturation();
    logic [1:0] tbl [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom); b = a; op = 3'($urandom); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      stat_clr = i == 5;
      tick();
      stat_clr = 1'b0;
      n_chk++; if (s_dlv !== 1'b1 || eq_count !== tbl[i])
        begin n_fail++; $display("FAIL sat_eq_count_%0d got=%0d dlv=%b exp=%0d", i, eq_count, s_dlv, tbl[i]); end
    end
  endtask

  task automatic test_reset_in_flight();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a = 8'($urandom); b = a; op = 3'($urandom);
      tick();
    end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++; if (s_ov !== 1'b0 || eq_count !== 2'd0)
        begin n_fail++; $display("FAIL flush_%0d got=ov%b cnt%0d exp=ov0 cnt0", i, s_ov, eq_count); end
    end
  endtask

  task automatic test_random();
    int bad = 0, dl = 0;
    for (int c = 0; c < 10000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      a = 8'($urandom); b = ($urandom_range(0, 7) == 0) ? a : 8'($urandom);
      op = 3'($urandom); out_ready = ($urandom_range(0, 9) < 7);
      stat_clr = ($urandom_range(0, 49) == 0);
      tick();
      if (s_dlv) begin
        dl++;
        n_chk++; if (!has_exp || s_got !== exp_r)
          begin n_fail++; bad++; if (bad < 10) $display("FAIL rand_result cyc=%0d got=%h exp=%h", c, s_got, exp_r); end
      end
      if (s_or) begin
        n_chk++; if (s_ir !== 1'b1) begin n_fail++; bad++; if (bad < 10) $display("FAIL rand_throughput cyc=%0d in_ready=%b exp=1", c, s_ir); end
      end
      n_chk++; if (eq_count !== 2'(eqm))
        begin n_fail++; bad++; if (bad < 10) $display("FAIL rand_eq_count cyc=%0d got=%0d exp=%0d", c, eq_count, eqm); end
    end
    in_valid = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_dlv) begin
        n_chk++; if (!has_exp || s_got !== exp_r) begin n_fail++; $display("FAIL rand_drain got=%h exp=%h", s_got, exp_r); end
      end
    end
    n_chk++; if (q.size() !== 0 || dl < 1000) begin n_fail++; $display("FAIL rand_lost left=%0d delivered=%0d exp left=0", q.size(), dl); end
  endtask

  initial begin
    test_reset();
    test_xnor_equal();
    test_all_ops();
    test_back_to_back_stall();
    test_saturation();
    test_reset_in_flight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
